hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline controller driving ID/IX register sequencing: decides per cycle whether the ID instruction advances, is replaced by a bubble (load-use) or is killed (IX redirect).
//  Shadows dest regs of instructions in IX and MEM, generates MX/WX/WM bypass selects latched into ID/IX alongside the instruction.
//  Sits beside the decoder; outputs feed ID/IX stall_in/flush/bypass inputs and the IF/ID + PC hold/flush controls.
// PARAMETERS
//  REG_W   5   register specifier width
//  CNT_W  16   width of saturating performance counters
// PORTS
//  clk               in   1      clock; all state updates on negedge clk, same edge as pipeline registers
//  rst_n             in   1      asynchronous, active-low reset
//  id_valid          in   1      ID holds a real instruction
//  id_rs / id_rt     in   REG_W  ID source specifiers
//  id_uses_rs/rt     in   1      ID instruction reads rs / rt
//  id_is_store       in   1      ID is a store (rt is store data)
//  id_is_load        in   1      ID is a load
//  id_write_to_reg   in   1      ID writes a register
//  id_dest           in   REG_W  ID destination (after rt/rd select)
//  ix_redirect       in   1      IX resolved taken branch/jump/jr/jal
//  stall_id          out  1      to ID/IX stall_in: bubble into IX
//  flush_id          out  1      to ID/IX flush: kill ID instruction
//  hold_if           out  1      freeze PC and IF/ID
//  flush_if          out  1      zero IF/ID
//  mx_op1_bypass/mx_op2_bypass/wx_op1_bypass/wx_op2_bypass/wm_data_bypass  out 1  bypass selects
//  ctrl_state        out  2      FSM state (debug)
//  stall_cnt, flush_cnt  out  CNT_W  saturating event counters
// BEHAVIOUR
//  Reset: ix_slot, mem_slot invalid; state RUN; counters 0. All outputs combinational from state/inputs, so all are 0 in reset.
//  Slot = {v, dest, is_load}. Match(x,s) = s.v & x!=0 & x==s.dest; $0 never matches.
//  load_use = id_valid & ix.is_load & ((id_uses_rs & Match(rs,ix)) | (id_uses_rt & Match(rt,ix) & !id_is_store)).
//  Store data dependent on IX load: no stall; wm_data_bypass=1.
//  Priority: ix_redirect > load_use > advance.
//   redirect: flush_id=1, flush_if=1, stall_id=0, hold_if=0; next state FLUSH.
//   load_use: stall_id=1, hold_if=1; next state BUBBLE.
//   else: all 0; next state RUN.
//  Bypass (only when advancing, else all 0; youngest wins):
//   mx_opN = uses & Match(src,ix) & !ix.is_load
//   wx_opN = uses & Match(src,mem) & !mx_opN
//   op1 uses rs, op2 uses rt.
//  Slot advance each negedge: mem_slot <= ix_slot; ix_slot <= advance ? {id_valid&id_write_to_reg, id_dest, id_is_load} : invalid.
//  BUBBLE: inserted bubble leaves ix_slot invalid; the held instruction re-evaluates and advances with wx bypass next cycle.
//  FLUSH: no special action; back-to-back redirects each flush.
//  Counters: stall_cnt +1 per load_use cycle, flush_cnt +1 per redirect cycle, saturate at all-ones.
//  Async reset mid-stall/flush: slots invalidated, outputs drop immediately, no carry-over.
// STRUCTURE
//  Shared pkg: REG_W, slot struct/field widths, FSM encoding (RUN=0, BUBBLE=1, FLUSH=2).
//  One sub-module: hazard_slot_pipe (2-deep slot shift register + match logic); counters inline.
// TESTING
//  lw $2 in IX, add $3,$2,$4 in ID -> stall_id=1, hold_if=1 one cycle; next cycle wx_op1_bypass=1, stall_cnt=1.
//  add $5 in IX, sub $6,$1,$5 in ID -> mx_op2_bypass=1, no stall; same dest in IX and MEM -> mx wins, wx=0.
//  lw $7 in IX, sw $7,0($8) in ID -> wm_data_bypass=1, stall_id=0; sw $9,0($7) -> stall_id=1.
//  ix_redirect=1 with load_use also true -> flush_id=flush_if=1, stall_id=0, bypass 0, flush_cnt=1.
//  Dest $0 in IX/MEM, ID reads $0 -> no bypass, no stall.
//  rst_n low during BUBBLE -> outputs 0 at once; after release first ID instruction sees no bypass.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the ID/IX hazard controller: the slot shadow of an in-flight
// destination register, the FSM encoding, and the register-match helper.
package hazard_ctrl_unit_pkg;
  localparam int REG_W = 5;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_FLUSH  = 2'd2
  } ctrl_state_e;

  // $0 is hardwired, so it never forms a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] x, input slot_t s);
    return s.v && (x != '0) && (x == s.dest);
  endfunction
endpackage

// File: rtl/hazard_slot_pipe.sv
// Two-deep shadow of the destinations held in IX and MEM, plus the source
// match terms the controller needs for stalls and bypass selects.
module hazard_slot_pipe
  import hazard_ctrl_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  slot_t            id_slot,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output slot_t            ix_slot,
  output slot_t            mem_slot,
  output logic             rs_ix,
  output logic             rt_ix,
  output logic             rs_mem,
  output logic             rt_mem
);
  // Stall or kill pushes an empty slot into IX; MEM always follows IX.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix_slot  <= SLOT_NONE;
      mem_slot <= SLOT_NONE;
    end else begin
      mem_slot <= ix_slot;
      ix_slot  <= adv ? id_slot : SLOT_NONE;
    end
  end

  assign rs_ix  = reg_match(rs, ix_slot);
  assign rt_ix  = reg_match(rt, ix_slot);
  assign rs_mem = reg_match(rs, mem_slot);
  assign rt_mem = reg_match(rt, mem_slot);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID/IX sequencing controller: redirect kill, load-use bubble, and the
// MX/WX/WM bypass selects latched into ID/IX with the advancing instruction.
module hazard_ctrl_unit #(
  parameter int REG_W = hazard_ctrl_unit_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_store,
  input  logic             id_is_load,
  input  logic             id_write_to_reg,
  input  logic [REG_W-1:0] id_dest,
  input  logic             ix_redirect,
  output logic             stall_id,
  output logic             flush_id,
  output logic             hold_if,
  output logic             flush_if,
  output logic             mx_op1_bypass,
  output logic             mx_op2_bypass,
  output logic             wx_op1_bypass,
  output logic             wx_op2_bypass,
  output logic             wm_data_bypass,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_ctrl_unit_pkg::*;

  slot_t       id_slot, ix_slot, mem_slot;
  logic        rs_ix, rt_ix, rs_mem, rt_mem;
  logic        load_use, advance;
  ctrl_state_e state_q, state_d;

  assign id_slot = '{v: id_valid & id_write_to_reg, dest: id_dest, is_load: id_is_load};

  hazard_slot_pipe u_slot_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (advance),
    .id_slot  (id_slot),
    .rs       (id_rs),
    .rt       (id_rt),
    .ix_slot  (ix_slot),
    .mem_slot (mem_slot),
    .rs_ix    (rs_ix),
    .rt_ix    (rt_ix),
    .rs_mem   (rs_mem),
    .rt_mem   (rt_mem)
  );

  // Store data from an IX load is covered by the WM path, so it never stalls.
  assign load_use = id_valid & ix_slot.is_load &
                    ((id_uses_rs & rs_ix) | (id_uses_rt & rt_ix & ~id_is_store));
  assign advance  = rst_n & ~ix_redirect & ~load_use;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = ST_RUN;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    hold_if        = 1'b0;
    flush_if       = 1'b0;
    mx_op1_bypass  = 1'b0;
    mx_op2_bypass  = 1'b0;
    wx_op1_bypass  = 1'b0;
    wx_op2_bypass  = 1'b0;
    wm_data_bypass = 1'b0;
    if (!rst_n) begin
      state_d = ST_RUN;
    end else if (ix_redirect) begin
      state_d  = ST_FLUSH;
      flush_id = 1'b1;
      flush_if = 1'b1;
    end else if (load_use) begin
      state_d  = ST_BUBBLE;
      stall_id = 1'b1;
      hold_if  = 1'b1;
    end else begin
      // IX result is younger than MEM, so MX suppresses WX on the same operand.
      mx_op1_bypass  = id_uses_rs & rs_ix & ~ix_slot.is_load;
      mx_op2_bypass  = id_uses_rt & rt_ix & ~ix_slot.is_load;
      wx_op1_bypass  = id_uses_rs & rs_mem & ~mx_op1_bypass;
      wx_op2_bypass  = id_uses_rt & rt_mem & ~mx_op2_bypass;
      wm_data_bypass = id_is_store & id_uses_rt & rt_ix & ix_slot.is_load;
    end
  end

  assign ctrl_state = state_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_id && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_id && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: hand-computed hazard/bypass vectors,
// counter saturation (narrow counters) and async reset during a bubble.
module tb_hazard_ctrl_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  localparam logic [8:0] NONE  = 9'b0_0000_0000;
  localparam logic [8:0] STALL = 9'b1_0000_0000;
  localparam logic [8:0] FL_ID = 9'b0_1000_0000;
  localparam logic [8:0] HOLD  = 9'b0_0100_0000;
  localparam logic [8:0] FL_IF = 9'b0_0010_0000;
  localparam logic [8:0] MX1   = 9'b0_0001_0000;
  localparam logic [8:0] MX2   = 9'b0_0000_1000;
  localparam logic [8:0] WX1   = 9'b0_0000_0100;
  localparam logic [8:0] WX2   = 9'b0_0000_0010;
  localparam logic [8:0] WM    = 9'b0_0000_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rs, id_uses_rt, id_is_store, id_is_load, id_write_to_reg;
  logic [REG_W-1:0] id_rs, id_rt, id_dest;
  logic ix_redirect;
  logic stall_id, flush_id, hold_if, flush_if;
  logic mx_op1_bypass, mx_op2_bypass, wx_op1_bypass, wx_op2_bypass, wm_data_bypass;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_store(id_is_store), .id_is_load(id_is_load),
    .id_write_to_reg(id_write_to_reg), .id_dest(id_dest),
    .ix_redirect(ix_redirect),
    .stall_id(stall_id), .flush_id(flush_id), .hold_if(hold_if), .flush_if(flush_if),
    .mx_op1_bypass(mx_op1_bypass), .mx_op2_bypass(mx_op2_bypass),
    .wx_op1_bypass(wx_op1_bypass), .wx_op2_bypass(wx_op2_bypass),
    .wm_data_bypass(wm_data_bypass),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {stall_id, flush_id, hold_if, flush_if,
                 mx_op1_bypass, mx_op2_bypass, wx_op1_bypass, wx_op2_bypass, wm_data_bypass};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // v, rs, rt, uses_rs, uses_rt, store, load, write, dest
  task automatic id_set(input int v, input int rs, input int rt, input int urs, input int urt,
                        input int st, input int ld, input int wr, input int dest);
    id_valid        = 1'(v);
    id_rs           = REG_W'(rs);
    id_rt           = REG_W'(rt);
    id_uses_rs      = 1'(urs);
    id_uses_rt      = 1'(urt);
    id_is_store     = 1'(st);
    id_is_load      = 1'(ld);
    id_write_to_reg = 1'(wr);
    id_dest         = REG_W'(dest);
  endtask

  // Inputs change after posedge; checks land mid high phase, before the negedge commit.
  task automatic step(input int v, input int rs, input int rt, input int urs, input int urt,
                      input int st, input int ld, input int wr, input int dest);
    @(posedge clk);
    id_set(v, rs, rt, urs, urt, st, ld, wr, dest);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ix_redirect = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("reset_outs", 32'(outs), 32'(NONE));
    check("reset_state", 32'(ctrl_state), 0);
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_flush_cnt", 32'(flush_cnt), 0);
    #1 rst_n = 1'b1;

    step(1, 0, 0, 1, 0, 0, 1, 1, 2);              // lw $2,0($0)
    check("lw2_outs", 32'(outs), 32'(NONE));
    step(1, 2, 4, 1, 1, 0, 0, 1, 3);              // add $3,$2,$4
    check("loaduse_outs", 32'(outs), 32'(STALL | HOLD));
    step(1, 2, 4, 1, 1, 0, 0, 1, 3);              // held add re-evaluates
    check("after_bubble_outs", 32'(outs), 32'(WX1));
    check("bubble_state", 32'(ctrl_state), 1);
    check("stall_cnt_1", 32'(stall_cnt), 1);
    step(1, 0, 0, 1, 1, 0, 0, 1, 5);              // add $5,$0,$0
    check("reads_r0_outs", 32'(outs), 32'(NONE));
    check("run_state", 32'(ctrl_state), 0);
    step(1, 1, 5, 1, 1, 0, 0, 1, 6);              // sub $6,$1,$5
    check("mx_op2_outs", 32'(outs), 32'(MX2));
    step(1, 6, 5, 1, 1, 0, 0, 1, 6);              // or $6,$6,$5
    check("mx1_wx2_outs", 32'(outs), 32'(MX1 | WX2));
    step(1, 6, 0, 1, 1, 0, 0, 1, 10);             // $6 in both IX and MEM
    check("mx_wins_outs", 32'(outs), 32'(MX1));
    step(1, 1, 0, 1, 0, 0, 1, 1, 7);              // lw $7,0($1)
    check("lw7_outs", 32'(outs), 32'(NONE));
    step(1, 8, 7, 1, 1, 1, 0, 0, 0);              // sw $7,0($8)
    check("store_data_wm_outs", 32'(outs), 32'(WM));
    id_set(1, 7, 9, 1, 1, 1, 0, 0, 0); #1;        // sw $9,0($7)
    check("store_addr_stall_outs", 32'(outs), 32'(STALL | HOLD));
    step(1, 7, 9, 1, 1, 1, 0, 0, 0);
    check("store_after_bubble_outs", 32'(outs), 32'(WX1));
    check("stall_cnt_2", 32'(stall_cnt), 2);
    step(1, 0, 0, 1, 0, 0, 1, 1, 4);              // lw $4,0($0)
    check("lw4_outs", 32'(outs), 32'(NONE));
    step(1, 4, 4, 1, 1, 0, 0, 1, 1);              // add $1,$4,$4 with redirect
    ix_redirect = 1'b1; #1;
    check("redirect_over_loaduse", 32'(outs), 32'(FL_ID | FL_IF));
    step(1, 4, 0, 1, 1, 0, 0, 1, 1);              // add $1,$4,$0
    ix_redirect = 1'b0; #1;
    check("after_flush_outs", 32'(outs), 32'(WX1));
    check("flush_state", 32'(ctrl_state), 2);
    check("flush_cnt_1", 32'(flush_cnt), 1);
    step(1, 2, 2, 1, 1, 0, 0, 1, 0);              // add $0,$2,$2
    check("dest0_in_outs", 32'(outs), 32'(NONE));
    step(1, 0, 0, 1, 0, 0, 1, 1, 0);              // lw $0,0($0)
    check("r0_vs_r0_outs", 32'(outs), 32'(NONE));
    step(1, 0, 0, 1, 1, 0, 0, 1, 3);              // add $3,$0,$0, lw $0 in IX
    check("r0_no_stall_outs", 32'(outs), 32'(NONE));

    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      ix_redirect = 1'b1; #1;
      if (i == 19) check("b2b_redirect_outs", 32'(outs), 32'(FL_ID | FL_IF));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ix_redirect = 1'b0; #1;
    check("flush_cnt_sat", 32'(flush_cnt), 15);
    check("b2b_state", 32'(ctrl_state), 2);

    step(1, 0, 0, 1, 0, 0, 1, 1, 2);              // lw $2,0($0)
    step(1, 2, 4, 1, 1, 0, 0, 1, 3);              // add $3,$2,$4
    check("loaduse2_outs", 32'(outs), 32'(STALL | HOLD));
    step(1, 2, 4, 1, 1, 0, 0, 1, 3);              // now in BUBBLE
    check("bubble2_state", 32'(ctrl_state), 1);
    rst_n = 1'b0; #1;
    check("rst_bubble_outs", 32'(outs), 32'(NONE));
    check("rst_bubble_state", 32'(ctrl_state), 0);
    check("rst_bubble_stall_cnt", 32'(stall_cnt), 0);
    check("rst_bubble_flush_cnt", 32'(flush_cnt), 0);
    rst_n = 1'b1; #1;
    check("post_rst_no_bypass", 32'(outs), 32'(NONE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
